// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
//   Bundles the requester, tick and transmitter signals of the UART transmit
//   scheduler. The clock and reset stay outside the bundle as plain ports.
//   master : the scheduler side. It drives gnt, tx_start, tx_data, busy and err.
//   slave  : the environment side (requesters, tick generator, UART TX). It
//            drives tick, req, req_data and tx_done.
interface uart_tx_sched_if;
    logic        tick;      // one-cycle tick pulse
    logic [3:0]  req;       // level requests, held until granted
    logic [31:0] req_data;  // byte i on [8i+7:8i]
    logic [3:0]  gnt;       // one-hot, one-cycle grant
    logic        tx_start;  // one-cycle start pulse to the transmitter
    logic [7:0]  tx_data;   // byte being transmitted
    logic        tx_done;   // end-of-frame pulse from the transmitter
    logic        busy;      // scheduler not idle
    logic        err;       // sticky timeout flag

    modport master (
        input  tick, req, req_data, tx_done,
        output gnt, tx_start, tx_data, busy, err
    );

    modport slave (
        output tick, req, req_data, tx_done,
        input  gnt, tx_start, tx_data, busy, err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Round-robin scheduler that shares one UART transmitter between four byte
//   requesters. Each grant issues a one-cycle tx_start with the captured byte.
//   After tx_done, the block waits GAP_TICKS tick pulses before it arbitrates
//   again.
//
//   Optional feature macro: UART_SCHED_TIMEOUT_EN
//     When defined, a WAIT that lasts TIMEOUT_TICKS ticks without tx_done
//     sets the sticky err flag and proceeds as if tx_done had arrived.
//     When undefined, WAIT lasts indefinitely and err is tied to 0.
//
//   Ports:
//     CLK  - system clock
//     RSTn - asynchronous active-low reset
//     bus  - uart_tx_sched_if.master (tick, req, req_data, gnt, tx_start,
//            tx_data, tx_done, busy, err)
module uart_tx_sched #(
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic            CLK,
    input  logic            RSTn,
    uart_tx_sched_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_e;

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  gnt_q, gnt_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;

    // Arbitration scratch
    logic        found;
    logic [1:0]  win;
    logic [1:0]  idx;

    // Destination after a frame ends. A zero gap skips GAP entirely.
    localparam state_e AFTER_FRAME = (GAP_TICKS == 0) ? IDLE : GAP;

`ifdef UART_SCHED_TIMEOUT_EN
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        err_q, err_d;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            gnt_q      <= 4'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            gap_cnt_q  <= 8'd0;
`ifdef UART_SCHED_TIMEOUT_EN
            to_cnt_q   <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef UART_SCHED_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = 4'd0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        gap_cnt_d  = gap_cnt_q;
`ifdef UART_SCHED_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
`endif

        // Winner is the first requester at or after ptr, wrapping mod 4.
        found = 1'b0;
        win   = ptr_q;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = 4'b0001 << win;
                    tx_start_d = 1'b1;
                    tx_data_d  = bus.req_data[{win, 3'b000} +: 8];
                    ptr_d      = win + 2'd1;
                    state_d    = WAIT;
`ifdef UART_SCHED_TIMEOUT_EN
                    to_cnt_d   = 8'd0;
`endif
                end
            end
            WAIT: begin
                // tx_done has priority over an expiring timeout tick. A tick
                // that coincides with tx_done is not counted as a gap tick.
                if (bus.tx_done) begin
                    gap_cnt_d = 8'd0;
                    state_d   = AFTER_FRAME;
                end
`ifdef UART_SCHED_TIMEOUT_EN
                else if (bus.tick) begin
                    if (to_cnt_q == 8'(TIMEOUT_TICKS - 1)) begin
                        err_d     = 1'b1;
                        gap_cnt_d = 8'd0;
                        state_d   = AFTER_FRAME;
                    end else begin
                        to_cnt_d  = to_cnt_q + 8'd1;
                    end
                end
`endif
            end
            GAP: begin
                if (bus.tick) begin
                    if (gap_cnt_q == 8'(GAP_TICKS - 1)) begin
                        gap_cnt_d = 8'd0;
                        state_d   = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt      = gnt_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = (state_q != IDLE);
`ifdef UART_SCHED_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
//   Directed bench for uart_tx_sched. dut_a uses GAP_TICKS=2 and
//   TIMEOUT_TICKS=3. dut_b uses GAP_TICKS=0 for the round-robin sequence.
module tb_uart_tx_sched;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_tx_sched_if ifa ();
    uart_tx_sched_if ifb ();

    uart_tx_sched #(.GAP_TICKS(2), .TIMEOUT_TICKS(3)) dut_a (.CLK(CLK), .RSTn(RSTn), .bus(ifa));
    uart_tx_sched #(.GAP_TICKS(0), .TIMEOUT_TICKS(3)) dut_b (.CLK(CLK), .RSTn(RSTn), .bus(ifb));

    always #5 CLK = ~CLK;

    // Advance n clock edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic tick_a;
        ifa.tick = 1'b1; cyc(); ifa.tick = 1'b0;
    endtask

    task automatic done_a;
        ifa.tx_done = 1'b1; cyc(); ifa.tx_done = 1'b0;
    endtask

    // {gnt, tx_start, tx_data, busy} of dut_a
    function automatic logic [13:0] vec_a();
        return {ifa.gnt, ifa.tx_start, ifa.tx_data, ifa.busy};
    endfunction

    task automatic test_single;
        ifa.req = 4'b0001; ifa.req_data = 32'h0000_00A5;
        cyc();
        checks++;
        if (vec_a() !== {4'b0001, 1'b1, 8'hA5, 1'b1}) begin
            errors++; $display("FAIL single_grant: got %h exp %h", vec_a(), {4'b0001, 1'b1, 8'hA5, 1'b1});
        end
        ifa.req = 4'b0000;
        cyc();
        checks++;
        if (vec_a() !== {4'b0000, 1'b0, 8'hA5, 1'b1}) begin
            errors++; $display("FAIL single_wait: got %h exp %h", vec_a(), {4'b0000, 1'b0, 8'hA5, 1'b1});
        end
        done_a();
        tick_a();
        checks++;
        if (ifa.busy !== 1'b1) begin
            errors++; $display("FAIL single_gap1: busy got %b exp 1", ifa.busy);
        end
        cyc(2);
        tick_a();
        checks++;
        if ({ifa.busy, ifa.gnt} !== 5'b0_0000) begin
            errors++; $display("FAIL single_idle: busy,gnt got %b exp 00000", {ifa.busy, ifa.gnt});
        end
    endtask

    task automatic test_round_robin;
        logic [31:0] d;
        int w;
        int e;
        d = 32'h4433_2211;
        ifb.req_data = d;
        ifb.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            e = n % 4;
            w = 0;
            while (ifb.tx_start !== 1'b1 && w < 20) begin
                cyc(); w++;
            end
            checks++;
            if (w >= 20) begin
                errors++; $display("FAIL rr_timeout: no tx_start for grant %0d within 20 cycles", n);
            end else if ({ifb.gnt, ifb.tx_data} !== {4'(4'b0001 << e), d[e*8 +: 8]}) begin
                errors++; $display("FAIL rr_grant%0d: gnt,data got %h exp %h", n,
                                   {ifb.gnt, ifb.tx_data}, {4'(4'b0001 << e), d[e*8 +: 8]});
            end
            if (n > 0) begin
                checks++;
                if (w !== 1) begin
                    errors++; $display("FAIL rr_spacing%0d: idle cycles got %0d exp 1", n, w);
                end
            end
            ifb.req[e] = 1'b0;
            cyc();
            ifb.req[e] = 1'b1;
            cyc(4);
            ifb.tx_done = 1'b1; cyc(); ifb.tx_done = 1'b0;
        end
        ifb.req = 4'b0000;
        cyc(2);
        checks++;
        if ({ifb.busy, ifb.tx_start} !== 2'b00) begin
            errors++; $display("FAIL rr_end: busy,tx_start got %b exp 00", {ifb.busy, ifb.tx_start});
        end
    endtask

    task automatic test_gap_count;
        ifa.req = 4'b0010; ifa.req_data = 32'h0000_7700;
        cyc();
        checks++;
        if (vec_a() !== {4'b0010, 1'b1, 8'h77, 1'b1}) begin
            errors++; $display("FAIL gap_grant: got %h exp %h", vec_a(), {4'b0010, 1'b1, 8'h77, 1'b1});
        end
        ifa.req = 4'b0000;
        cyc();
        ifa.tx_done = 1'b1; ifa.tick = 1'b1;
        cyc();
        ifa.tx_done = 1'b0; ifa.tick = 1'b0;
        cyc(2);
        tick_a();
        checks++;
        if (ifa.busy !== 1'b1) begin
            errors++; $display("FAIL gap_coincident_tick: busy got %b exp 1", ifa.busy);
        end
        ifa.req = 4'b0100; ifa.req_data = 32'h0099_0000;
        cyc(2);
        checks++;
        if ({ifa.busy, ifa.gnt} !== 5'b1_0000) begin
            errors++; $display("FAIL gap_req_ignored: busy,gnt got %b exp 10000", {ifa.busy, ifa.gnt});
        end
        tick_a();
        checks++;
        if ({ifa.busy, ifa.gnt, ifa.tx_start} !== 6'b0_0000_0) begin
            errors++; $display("FAIL gap_second_tick: busy,gnt,start got %b exp 000000", {ifa.busy, ifa.gnt, ifa.tx_start});
        end
        cyc();
        checks++;
        if (vec_a() !== {4'b0100, 1'b1, 8'h99, 1'b1}) begin
            errors++; $display("FAIL gap_pending_grant: got %h exp %h", vec_a(), {4'b0100, 1'b1, 8'h99, 1'b1});
        end
        ifa.req = 4'b0000;
        done_a(); tick_a(); tick_a();
    endtask

    task automatic test_spurious;
        done_a();
        checks++;
        if (vec_a() !== {4'b0000, 1'b0, 8'h99, 1'b0}) begin
            errors++; $display("FAIL spur_idle: got %h exp %h", vec_a(), {4'b0000, 1'b0, 8'h99, 1'b0});
        end
        ifa.req = 4'b1000; ifa.req_data = 32'hC300_0000;
        cyc();
        checks++;
        if (vec_a() !== {4'b1000, 1'b1, 8'hC3, 1'b1}) begin
            errors++; $display("FAIL spur_grant: got %h exp %h", vec_a(), {4'b1000, 1'b1, 8'hC3, 1'b1});
        end
        ifa.req = 4'b0000;
        done_a();
        tick_a();
        done_a();
        checks++;
        if (vec_a() !== {4'b0000, 1'b0, 8'hC3, 1'b1}) begin
            errors++; $display("FAIL spur_gap: got %h exp %h", vec_a(), {4'b0000, 1'b0, 8'hC3, 1'b1});
        end
        tick_a();
        checks++;
        if (vec_a() !== {4'b0000, 1'b0, 8'hC3, 1'b0}) begin
            errors++; $display("FAIL spur_gap_count: got %h exp %h", vec_a(), {4'b0000, 1'b0, 8'hC3, 1'b0});
        end
    endtask

    task automatic test_timeout;
        ifa.req = 4'b0001; ifa.req_data = 32'h0000_003C;
        cyc();
        checks++;
        if ({ifa.gnt, ifa.tx_data} !== {4'b0001, 8'h3C}) begin
            errors++; $display("FAIL to_grant: gnt,data got %h exp %h", {ifa.gnt, ifa.tx_data}, {4'b0001, 8'h3C});
        end
        ifa.req = 4'b0000;
`ifdef UART_SCHED_TIMEOUT_EN
        // tx_done arriving with the expiring tick wins; err stays clear
        tick_a(); tick_a();
        ifa.tick = 1'b1; ifa.tx_done = 1'b1;
        cyc();
        ifa.tick = 1'b0; ifa.tx_done = 1'b0;
        checks++;
        if ({ifa.busy, ifa.err} !== 2'b10) begin
            errors++; $display("FAIL to_tie: busy,err got %b exp 10", {ifa.busy, ifa.err});
        end
        tick_a(); tick_a();
        ifa.req = 4'b0010; ifa.req_data = 32'h0000_2D00;
        cyc();
        checks++;
        if ({ifa.gnt, ifa.tx_data} !== {4'b0010, 8'h2D}) begin
            errors++; $display("FAIL to_grant2: gnt,data got %h exp %h", {ifa.gnt, ifa.tx_data}, {4'b0010, 8'h2D});
        end
        ifa.req = 4'b0000;
        tick_a(); tick_a();
        checks++;
        if ({ifa.busy, ifa.err} !== 2'b10) begin
            errors++; $display("FAIL to_before: busy,err got %b exp 10", {ifa.busy, ifa.err});
        end
        tick_a();
        checks++;
        if ({ifa.busy, ifa.err} !== 2'b11) begin
            errors++; $display("FAIL to_expire: busy,err got %b exp 11", {ifa.busy, ifa.err});
        end
        tick_a(); tick_a();
        checks++;
        if ({ifa.busy, ifa.err} !== 2'b01) begin
            errors++; $display("FAIL to_gap_end: busy,err got %b exp 01", {ifa.busy, ifa.err});
        end
        ifa.req = 4'b0100; ifa.req_data = 32'h004D_0000;
        cyc();
        checks++;
        if ({ifa.gnt, ifa.tx_start, ifa.tx_data, ifa.err} !== {4'b0100, 1'b1, 8'h4D, 1'b1}) begin
            errors++; $display("FAIL to_next_grant: got %h exp %h",
                               {ifa.gnt, ifa.tx_start, ifa.tx_data, ifa.err}, {4'b0100, 1'b1, 8'h4D, 1'b1});
        end
        ifa.req = 4'b0000;
        done_a(); tick_a(); tick_a();
        checks++;
        if ({ifa.busy, ifa.err} !== 2'b01) begin
            errors++; $display("FAIL to_sticky: busy,err got %b exp 01", {ifa.busy, ifa.err});
        end
`else
        tick_a(); tick_a(); tick_a();
        checks++;
        if ({ifa.busy, ifa.err} !== 2'b10) begin
            errors++; $display("FAIL to_none3: busy,err got %b exp 10", {ifa.busy, ifa.err});
        end
        tick_a(); tick_a();
        checks++;
        if ({ifa.busy, ifa.err} !== 2'b10) begin
            errors++; $display("FAIL to_none5: busy,err got %b exp 10", {ifa.busy, ifa.err});
        end
        done_a(); tick_a(); tick_a();
        checks++;
        if ({ifa.busy, ifa.err} !== 2'b00) begin
            errors++; $display("FAIL to_none_end: busy,err got %b exp 00", {ifa.busy, ifa.err});
        end
`endif
    endtask

    task automatic test_reset;
        ifa.req = 4'b1111; ifa.req_data = 32'h5A5A_5A5A;
        cyc();
        ifa.req = 4'b0000;
        cyc();
        checks++;
        if ({ifa.tx_data, ifa.busy} !== {8'h5A, 1'b1}) begin
            errors++; $display("FAIL rst_setup: data,busy got %h exp %h", {ifa.tx_data, ifa.busy}, {8'h5A, 1'b1});
        end
        #2 RSTn = 1'b0;
        #1;
        checks++;
        if ({vec_a(), ifa.err} !== 15'd0) begin
            errors++; $display("FAIL rst_async: got %h exp 0", {vec_a(), ifa.err});
        end
        cyc();
        RSTn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if ({ifa.tx_start, ifa.busy} !== 2'b00) begin
                errors++; $display("FAIL rst_no_restart%0d: start,busy got %b exp 00", i, {ifa.tx_start, ifa.busy});
            end
        end
        // ptr is back at 0, so requester 0 wins the full set
        ifa.req = 4'b1111; ifa.req_data = 32'h4433_2211;
        cyc();
        checks++;
        if (vec_a() !== {4'b0001, 1'b1, 8'h11, 1'b1}) begin
            errors++; $display("FAIL rst_ptr: got %h exp %h", vec_a(), {4'b0001, 1'b1, 8'h11, 1'b1});
        end
        ifa.req = 4'b0000;
        done_a(); tick_a(); tick_a();
    endtask

    initial begin
        ifa.tick = 1'b0; ifa.req = 4'b0; ifa.req_data = 32'h0; ifa.tx_done = 1'b0;
        ifb.tick = 1'b0; ifb.req = 4'b0; ifb.req_data = 32'h0; ifb.tx_done = 1'b0;
        RSTn = 1'b0;
        cyc(2);
        checks++;
        if ({vec_a(), ifa.err} !== 15'd0) begin
            errors++; $display("FAIL reset_state: got %h exp 0", {vec_a(), ifa.err});
        end
        RSTn = 1'b1;
        cyc();
        test_single();
        test_round_robin();
        test_gap_count();
        test_spurious();
        test_timeout();
        test_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter between four byte requesters. It paces frames with the periodic tick from the 1 ms tick generator. Each granted byte is issued to the transmitter with a one-cycle start pulse. After the transmitter reports completion, the block enforces a programmable inter-frame gap, counted in ticks, before it arbitrates again.

## Interface
Parameters:
- GAP_TICKS, 2, number of tick pulses to wait after tx_done before the next grant (0 = no gap); 8-bit counter
- TIMEOUT_TICKS, 20, ticks allowed in WAIT before abort (only with UART_SCHED_TIMEOUT_EN); 8-bit counter

Ports:
- CLK  in  1  system clock; the only clock
- RSTn  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle pulse from the tick generator
- req  in  4  level requests; req[i] is held until gnt[i]
- req_data  in  32  byte of requester i on [8i+7:8i]
- gnt  out  4  one-hot, one-cycle grant; req_data of that requester is captured
- tx_start  out  1  one-cycle pulse to the UART transmitter
- tx_data  out  8  byte being transmitted; stable from tx_start until the next grant
- tx_done  in  1  one-cycle pulse from the transmitter at the end of a frame
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky timeout flag; tied 0 when the macro is undefined

## Operation
- States: IDLE, WAIT, GAP.
- Round-robin pointer ptr (2 bits) marks the highest-priority requester. Search order is ptr, ptr+1, … mod 4.
- IDLE with req != 0 at a clock edge:
  - the winner i is the first set bit in search order;
  - registered results: gnt[i]=1, tx_start=1, tx_data=req_data[i], ptr=i+1 mod 4, state=WAIT.
- IDLE with req == 0: no action.
- WAIT: the block ignores req and waits for tx_done.
  - On tx_done: go to GAP and clear the gap counter.
  - If GAP_TICKS==0, go directly to IDLE instead.
- GAP:
  - each tick increments the gap counter;
  - on the GAP_TICKS-th tick the block goes to IDLE;
  - req is ignored.
- tx_done outside WAIT is ignored.
- A tick in the same cycle as the tx_done that leaves WAIT is not counted.
- A requester must drop req[i] in the cycle after gnt[i]. If req[i] is still high when the block returns to IDLE, it is treated as a new request.
- Reset values: state=IDLE, ptr=0, gnt=0, tx_start=0, tx_data=8'h00, busy=0, err=0, all counters 0.
- Reset mid-operation asynchronously returns everything to the reset values. Any in-flight frame is abandoned, and tx_start is not re-issued.

## Timing
- Grant latency is 1 cycle. For req sampled at edge k, gnt and tx_start are high for the cycle after edge k, and busy rises with them.
- Minimum spacing between two tx_start pulses is 1 cycle (the tx_done cycle) plus the GAP_TICKS tick periods plus 1 cycle in IDLE.
- tx_done is accepted from the tx_start cycle onward. The transmitter must not assert it earlier.
- busy falls in the cycle that IDLE is entered. An IDLE cycle with req pending lasts exactly 1 cycle.

## Configuration
- Macro: UART_SCHED_TIMEOUT_EN.
- Defined:
  - an 8-bit timeout counter is cleared on entry to WAIT and counts ticks while in WAIT;
  - on the TIMEOUT_TICKS-th tick without tx_done, err is set to 1 (sticky until RSTn) and the block goes to GAP as if tx_done had arrived;
  - tx_done and the expiring tick in the same cycle: tx_done wins and err is unchanged.
- Undefined: no timeout counter; WAIT lasts indefinitely; err is constant 0.

## Test plan
- Reset: assert RSTn=0 mid-WAIT with tx_data=8'h5A → state IDLE, gnt=0, tx_start=0, tx_data=8'h00, busy=0, err=0 immediately, and no tx_start after release.
- Single request: req=4'b0001, req_data[7:0]=8'hA5 → the next cycle has gnt=4'b0001, tx_start=1, tx_data=8'hA5; after tx_done and 2 ticks, busy=0.
- Round robin: req held at 4'b1111 (each bit re-raised after its grant), tx_done 5 cycles after each start, GAP_TICKS=0 → grant order 0,1,2,3,0 with tx_data following req_data.
- Gap counting: a tick coincident with tx_done → still busy after the next tick; IDLE on the second tick after tx_done; a pending req is granted the following cycle.
- Timeout (macro defined, TIMEOUT_TICKS=3): tx_done withheld → err=1 on the third tick in WAIT, then GAP; next grant proceeds normally and err stays 1. With the macro undefined, the same stimulus keeps busy=1 and err=0.
- Spurious done: tx_done pulses in IDLE and in GAP → no state change, no grant, gap count unaffected.
